multicycle_control: RTL and testbench

- Moore/Mealy FSM that sequences a multi-cycle RV32I datapath with a unified instruction/data memory.
- Supports R-type (0x33), I-type logic (0x13), LUI (0x37), SW (0x23), LW (0x03) and BEQ (0x63).
- Handles variable-latency memory through a ready handshake, with a wait-state timeout.
- Drives PC, IR, register-file, ALU-mux and memory enables; the datapath registers (PC, OldPC, IR, ALUOut, MDR) live outside this block.

---
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle RV32I datapath with a unified instruction/data memory.
// It drives the datapath enables and mux selects, waits on memory ready, and traps on timeouts or illegal opcodes.
module multicycle_control #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OP_i,
  input  logic       Zero_i,
  input  logic       Mem_Ready_i,
  output logic       PC_Write_o,
  output logic       IR_Write_o,
  output logic       I_or_D_o,
  output logic       Mem_Read_o,
  output logic       Mem_Write_o,
  output logic       Reg_Write_o,
  output logic       Mem_to_Reg_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [2:0] ALU_Op_o,
  output logic       PC_Src_o,
  output logic       Instr_Done_o,
  output logic       Illegal_Op_o,
  output logic       Timeout_o,
  output logic [3:0] State_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_EXEC_LUI = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_ALU_WB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OPC_R    = 7'h33;
  localparam logic [6:0] OPC_I    = 7'h13;
  localparam logic [6:0] OPC_LUI  = 7'h37;
  localparam logic [6:0] OPC_SW   = 7'h23;
  localparam logic [6:0] OPC_LW   = 7'h03;
  localparam logic [6:0] OPC_BEQ  = 7'h63;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             mem_wait;

  // A memory state that is not being completed this cycle counts as a wait cycle.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR))
                    && !Mem_Ready_i;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (Mem_Ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (OP_i)
          OPC_R:          state_d = S_EXEC_R;
          OPC_I:          state_d = S_EXEC_I;
          OPC_LUI:        state_d = S_EXEC_LUI;
          OPC_LW, OPC_SW: state_d = S_MEM_ADDR;
          OPC_BEQ:        state_d = S_BRANCH;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_LUI: state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: begin
        if (OP_i == OPC_LW) state_d = S_MEM_RD;
        else if (OP_i == OPC_SW) state_d = S_MEM_WR;
        else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_MEM_RD:   if (Mem_Ready_i) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (Mem_Ready_i) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase

    if (mem_wait && (cnt_q == LIMIT_M1)) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end

    // Counter measures only the current wait state, so it restarts on any transition.
    if (state_d != state_q)                 cnt_d = '0;
    else if (mem_wait && (cnt_q != '1))     cnt_d = cnt_q + 1'b1;
    else                                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decode the registered state (plus ready/zero where noted), so reset clears them at once.
  always_comb begin
    PC_Write_o   = 1'b0;
    IR_Write_o   = 1'b0;
    I_or_D_o     = 1'b0;
    Mem_Read_o   = 1'b0;
    Mem_Write_o  = 1'b0;
    Reg_Write_o  = 1'b0;
    Mem_to_Reg_o = 1'b0;
    ALU_Src_A_o  = 2'b00;
    ALU_Src_B_o  = 2'b00;
    ALU_Op_o     = 3'b000;
    PC_Src_o     = 1'b0;
    Instr_Done_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        Mem_Read_o  = 1'b1;
        ALU_Src_B_o = 2'b01;
        ALU_Op_o    = 3'b011;
        PC_Write_o  = Mem_Ready_i;
        IR_Write_o  = Mem_Ready_i;
      end
      S_DECODE: begin
        ALU_Src_A_o = 2'b10;
        ALU_Src_B_o = 2'b10;
        ALU_Op_o    = 3'b011;
      end
      S_EXEC_R: begin
        ALU_Src_A_o = 2'b01;
        ALU_Src_B_o = 2'b00;
        ALU_Op_o    = 3'b000;
      end
      S_EXEC_I: begin
        ALU_Src_A_o = 2'b01;
        ALU_Src_B_o = 2'b10;
        ALU_Op_o    = 3'b001;
      end
      S_EXEC_LUI: begin
        ALU_Src_A_o = 2'b01;
        ALU_Src_B_o = 2'b10;
        ALU_Op_o    = 3'b010;
      end
      S_MEM_ADDR: begin
        ALU_Src_A_o = 2'b01;
        ALU_Src_B_o = 2'b10;
        ALU_Op_o    = 3'b011;
      end
      S_ALU_WB: begin
        Reg_Write_o  = 1'b1;
        Instr_Done_o = 1'b1;
      end
      S_MEM_RD: begin
        Mem_Read_o = 1'b1;
        I_or_D_o   = 1'b1;
      end
      S_MEM_WB: begin
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = 1'b1;
        Instr_Done_o = 1'b1;
      end
      S_MEM_WR: begin
        Mem_Write_o  = 1'b1;
        I_or_D_o     = 1'b1;
        Instr_Done_o = Mem_Ready_i;
      end
      S_BRANCH: begin
        ALU_Src_A_o  = 2'b01;
        ALU_Src_B_o  = 2'b00;
        ALU_Op_o     = 3'b101;
        PC_Src_o     = 1'b1;
        PC_Write_o   = Zero_i;
        Instr_Done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign Illegal_Op_o = illegal_q;
  assign Timeout_o    = timeout_q;
  assign State_o      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: the driver queues per-cycle expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

  localparam int W = 22;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       ready;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg;
  logic [1:0] src_a, src_b;
  logic [2:0] alu_op;
  logic       pc_src, instr_done, illegal_op, timeout;
  logic [3:0] state;

  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           step_n;
  int           tests_run;
  int           fails;

  multicycle_control #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .OP_i         (op),
    .Zero_i       (zero),
    .Mem_Ready_i  (ready),
    .PC_Write_o   (pc_write),
    .IR_Write_o   (ir_write),
    .I_or_D_o     (i_or_d),
    .Mem_Read_o   (mem_read),
    .Mem_Write_o  (mem_write),
    .Reg_Write_o  (reg_write),
    .Mem_to_Reg_o (mem_to_reg),
    .ALU_Src_A_o  (src_a),
    .ALU_Src_B_o  (src_b),
    .ALU_Op_o     (alu_op),
    .PC_Src_o     (pc_src),
    .Instr_Done_o (instr_done),
    .Illegal_Op_o (illegal_op),
    .Timeout_o    (timeout),
    .State_o      (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word for a state, built from the per-state control table.
  function automatic logic [W-1:0] exp_vec(input logic [3:0] st, input logic rdy, input logic z,
                                           input logic ill, input logic to);
    logic pcw, irw, iod, mr, mw, rw, m2r, pcs, dn;
    logic [1:0] a, b;
    logic [2:0] o;
    {pcw, irw, iod, mr, mw, rw, m2r, pcs, dn} = '0;
    a = 2'b00; b = 2'b00; o = 3'b000;
    case (st)
      4'd1:  begin mr = 1; b = 2'b01; o = 3'b011; pcw = rdy; irw = rdy; end
      4'd2:  begin a = 2'b10; b = 2'b10; o = 3'b011; end
      4'd3:  begin a = 2'b01; b = 2'b00; o = 3'b000; end
      4'd4:  begin a = 2'b01; b = 2'b10; o = 3'b001; end
      4'd5:  begin a = 2'b01; b = 2'b10; o = 3'b010; end
      4'd6:  begin a = 2'b01; b = 2'b10; o = 3'b011; end
      4'd7:  begin mr = 1; iod = 1; end
      4'd8:  begin rw = 1; m2r = 1; dn = 1; end
      4'd9:  begin mw = 1; iod = 1; dn = rdy; end
      4'd10: begin rw = 1; dn = 1; end
      4'd11: begin a = 2'b01; b = 2'b00; o = 3'b101; pcs = 1; pcw = z; dn = 1; end
      default: ;
    endcase
    return {pcw, irw, iod, mr, mw, rw, m2r, a, b, o, pcs, dn, ill, to, st};
  endfunction

  // Driver tasks
  task automatic step(input logic [6:0] o, input logic z, input logic r,
                      input logic [3:0] st, input logic ill, input logic to);
    @(posedge clk);
    #1;
    op = o; zero = z; ready = r;
    step_n++;
    exp_q.push_back(exp_vec(st, r, z, ill, to));
    id_q.push_back(step_n);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step_n++;
    exp_q.push_back(exp_vec(4'd0, ready, zero, 1'b0, 1'b0));
    id_q.push_back(step_n);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step_n++;
    exp_q.push_back(exp_vec(4'd0, ready, zero, 1'b0, 1'b0));
    id_q.push_back(step_n);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] got, exp;
      int id;
      exp = exp_q.pop_front();
      id  = id_q.pop_front();
      got = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
             src_a, src_b, alu_op, pc_src, instr_done, illegal_op, timeout, state};
      tests_run++;
      if (got !== exp) begin
        fails++;
        $display("FAIL step%0d: got %b (state %0d) expected %b (state %0d)",
                 id, got, got[3:0], exp, exp[3:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; op = 7'h00; zero = 1'b0; ready = 1'b1;
    step_n = 0; tests_run = 0; fails = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // R-type stream, twice
    for (int i = 0; i < 2; i++) begin
      step(7'h33, 1, 1, 4'd1, 0, 0);
      step(7'h33, 1, 1, 4'd2, 0, 0);
      step(7'h33, 1, 1, 4'd3, 0, 0);
      step(7'h33, 1, 1, 4'd10, 0, 0);
    end
    // I-type logic and LUI
    step(7'h13, 0, 1, 4'd1, 0, 0);
    step(7'h13, 0, 1, 4'd2, 0, 0);
    step(7'h13, 0, 1, 4'd4, 0, 0);
    step(7'h13, 0, 1, 4'd10, 0, 0);
    step(7'h37, 0, 1, 4'd1, 0, 0);
    step(7'h37, 0, 1, 4'd2, 0, 0);
    step(7'h37, 0, 1, 4'd5, 0, 0);
    step(7'h37, 0, 1, 4'd10, 0, 0);
    // LW with fetch waits and read waits; three waits each stays inside the limit of 4
    for (int i = 0; i < 3; i++) step(7'h03, 0, 0, 4'd1, 0, 0);
    step(7'h03, 0, 1, 4'd1, 0, 0);
    step(7'h03, 0, 1, 4'd2, 0, 0);
    step(7'h03, 0, 1, 4'd6, 0, 0);
    for (int i = 0; i < 3; i++) step(7'h03, 0, 0, 4'd7, 0, 0);
    step(7'h03, 0, 1, 4'd7, 0, 0);
    step(7'h03, 0, 1, 4'd8, 0, 0);
    // SW, no waits
    step(7'h23, 0, 1, 4'd1, 0, 0);
    step(7'h23, 0, 1, 4'd2, 0, 0);
    step(7'h23, 0, 1, 4'd6, 0, 0);
    step(7'h23, 0, 1, 4'd9, 0, 0);
    // BEQ taken then not taken
    step(7'h63, 1, 1, 4'd1, 0, 0);
    step(7'h63, 1, 1, 4'd2, 0, 0);
    step(7'h63, 1, 1, 4'd11, 0, 0);
    step(7'h63, 0, 1, 4'd1, 0, 0);
    step(7'h63, 0, 1, 4'd2, 0, 0);
    step(7'h63, 0, 1, 4'd11, 0, 0);
    // SW with ready arriving on the last allowed wait cycle
    step(7'h23, 0, 1, 4'd1, 0, 0);
    step(7'h23, 0, 1, 4'd2, 0, 0);
    step(7'h23, 0, 1, 4'd6, 0, 0);
    for (int i = 0; i < 3; i++) step(7'h23, 0, 0, 4'd9, 0, 0);
    step(7'h23, 0, 1, 4'd9, 0, 0);
    // Illegal opcode traps and holds
    step(7'h7F, 0, 1, 4'd1, 0, 0);
    step(7'h7F, 0, 1, 4'd2, 0, 0);
    for (int i = 0; i < 20; i++) step(7'h7F, i[0], i[1], 4'd15, 1, 0);
    do_reset();
    // SW timeout
    step(7'h23, 0, 1, 4'd1, 0, 0);
    step(7'h23, 0, 1, 4'd2, 0, 0);
    step(7'h23, 0, 1, 4'd6, 0, 0);
    for (int i = 0; i < 4; i++) step(7'h23, 0, 0, 4'd9, 0, 0);
    for (int i = 0; i < 3; i++) step(7'h23, 0, 1, 4'd15, 0, 1);
    do_reset();
    // Reset during a pending fetch drops the request immediately
    step(7'h33, 0, 0, 4'd1, 0, 0);
    step(7'h33, 0, 0, 4'd1, 0, 0);
    do_reset();
    step(7'h33, 0, 1, 4'd1, 0, 0);
    step(7'h33, 0, 1, 4'd2, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      tests_run++;
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
